// File: rtl/pool_pingpong_ctrl.sv
// Ping-pong bank controller between a pooling engine (writer) and a consumer (reader).
// Two banks cycle EMPTY->FILL->FULL->DRAIN; frames are drained strictly in write order.
module pool_pingpong_ctrl #(
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       layer_go,
  input  logic [FRAME_CNT_WIDTH-1:0] num_frames,
  input  logic                       pool_done,
  input  logic                       rd_done,
  output logic                       pool_start,
  output logic                       wr_bank,
  output logic                       frame_ready,
  output logic                       rd_bank,
  output logic                       busy,
  output logic                       layer_done,
  output logic                       err_proto
);

  typedef enum logic {S_IDLE, S_RUN} top_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_t;

  top_t                       state_q, state_d;
  bank_t                      bank_q [2];
  bank_t                      bank_d [2];
  logic [FRAME_CNT_WIDTH-1:0] num_q, num_d;
  logic [FRAME_CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [FRAME_CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic                       pool_start_q, pool_start_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       frame_ready_q, frame_ready_d;
  logic                       rd_bank_q, rd_bank_d;
  logic                       busy_q, busy_d;
  logic                       layer_done_q, layer_done_d;
  logic                       err_q, err_d;

  logic fill_any;
  logic drain_any;
  logic oth;

  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    num_d         = num_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    err_d         = err_q;
    layer_done_d  = 1'b0;

    fill_any  = (bank_q[0] == B_FILL)  || (bank_q[1] == B_FILL);
    drain_any = (bank_q[0] == B_DRAIN) || (bank_q[1] == B_DRAIN);
    oth       = ~wr_bank_q;

    case (state_q)
      S_IDLE: begin
        if (layer_go) begin
          err_d = 1'b0;
          if (num_frames == '0) begin
            layer_done_d = 1'b1;
          end else begin
            state_d   = S_RUN;
            num_d     = num_frames;
            bank_d[0] = B_FILL;
            bank_d[1] = B_EMPTY;
            wr_bank_d = 1'b0;
            rd_ptr_d  = 1'b0;
            rd_bank_d = 1'b0;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
          end
        end
      end
      S_RUN: begin
        if (!drain_any && bank_q[rd_ptr_q] == B_FULL) begin
          bank_d[rd_ptr_q] = B_DRAIN;
          rd_bank_d        = rd_ptr_q;
        end
        // The filling bank is always wr_bank; completion frees the writer to claim the other bank.
        if (pool_done && fill_any) begin
          bank_d[wr_bank_q] = B_FULL;
          wr_cnt_d          = wr_cnt_q + 1'b1;
        end
        if ((!fill_any || pool_done) && wr_cnt_d != num_q && bank_q[oth] == B_EMPTY) begin
          bank_d[oth] = B_FILL;
          wr_bank_d   = oth;
        end
        if (rd_done && drain_any) begin
          bank_d[rd_ptr_q] = B_EMPTY;
          rd_cnt_d         = rd_cnt_q + 1'b1;
          rd_ptr_d         = ~rd_ptr_q;
          if (rd_cnt_d == num_q) begin
            state_d      = S_IDLE;
            bank_d[0]    = B_EMPTY;
            bank_d[1]    = B_EMPTY;
            layer_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((pool_done && !fill_any) || (rd_done && !drain_any)) begin
      err_d = 1'b1;
    end

    busy_d        = (state_d == S_RUN);
    pool_start_d  = (state_d == S_RUN) && ((bank_d[0] == B_FILL) || (bank_d[1] == B_FILL));
    frame_ready_d = (state_d == S_RUN) && ((bank_d[0] == B_DRAIN) || (bank_d[1] == B_DRAIN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bank_q[0]     <= B_EMPTY;
      bank_q[1]     <= B_EMPTY;
      num_q         <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      rd_ptr_q      <= 1'b0;
      pool_start_q  <= 1'b0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      rd_bank_q     <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      num_q         <= num_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      pool_start_q  <= pool_start_d;
      wr_bank_q     <= wr_bank_d;
      frame_ready_q <= frame_ready_d;
      rd_bank_q     <= rd_bank_d;
      busy_q        <= busy_d;
      layer_done_q  <= layer_done_d;
      err_q         <= err_d;
    end
  end

  assign pool_start  = pool_start_q;
  assign wr_bank     = wr_bank_q;
  assign frame_ready = frame_ready_q;
  assign rd_bank     = rd_bank_q;
  assign busy        = busy_q;
  assign layer_done  = layer_done_q;
  assign err_proto   = err_q;

endmodule

// File: tb/tb_pool_pingpong_ctrl.sv
// Bench for pool_pingpong_ctrl: directed vector table, reset sequence, then random pulses
// checked against a queue-based model of bank ownership.
module tb_pool_pingpong_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       layer_go;
  logic [7:0] num_frames;
  logic       pool_done;
  logic       rd_done;
  logic       pool_start, wr_bank, frame_ready, rd_bank, busy, layer_done, err_proto;
  logic [6:0] act;

  int checks = 0;
  int errors = 0;

  pool_pingpong_ctrl #(.FRAME_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .layer_go(layer_go), .num_frames(num_frames),
    .pool_done(pool_done), .rd_done(rd_done), .pool_start(pool_start),
    .wr_bank(wr_bank), .frame_ready(frame_ready), .rd_bank(rd_bank),
    .busy(busy), .layer_done(layer_done), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  // {pool_start, wr_bank, frame_ready, rd_bank, busy, layer_done, err_proto}
  assign act = {pool_start, wr_bank, frame_ready, rd_bank, busy, layer_done, err_proto};

  typedef struct {
    bit         go;
    int         nf;
    bit         pd;
    bit         rd;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(bit g, int n, bit p, bit r, logic [6:0] e);
    vec_t v;
    v.go = g; v.nf = n; v.pd = p; v.rd = r; v.exp = e;
    return v;
  endfunction

  task automatic drive(input bit g, input int n, input bit p, input bit r);
    @(negedge clk);
    layer_go   = g;
    num_frames = 8'(n);
    pool_done  = p;
    rd_done    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  // Model: which bank is filling / draining, and FIFO of full banks in write order.
  bit m_run, m_ld, m_err;
  int m_fill, m_drain, m_last_wr, m_rdb, m_written, m_read, m_nf;
  int m_full_q[$];

  task automatic model_reset();
    m_run = 0; m_ld = 0; m_err = 0;
    m_fill = -1; m_drain = -1; m_last_wr = 0; m_rdb = 0;
    m_written = 0; m_read = 0; m_nf = 0;
    m_full_q.delete();
  endtask

  function automatic bit bank_empty(int b);
    foreach (m_full_q[i]) if (m_full_q[i] == b) return 1'b0;
    return (m_fill != b) && (m_drain != b);
  endfunction

  task automatic model_step(input bit g, input int n, input bit p, input bit r);
    bit ld_n = 0;
    bit err_n = m_err;
    int oth = 1 - m_last_wr;
    bit oth_empty = bank_empty(oth);
    int f0 = m_fill;
    int d0 = m_drain;
    if (!m_run) begin
      if (g) begin
        err_n = 0;
        if (n == 0) ld_n = 1;
        else begin
          m_run = 1; m_nf = n; m_fill = 0; m_last_wr = 0; m_rdb = 0;
          m_written = 0; m_read = 0; m_drain = -1; m_full_q.delete();
        end
      end
      if (p || r) err_n = 1;
    end else begin
      if (d0 < 0 && m_full_q.size() > 0) begin
        m_drain = m_full_q.pop_front();
        m_rdb   = m_drain;
      end
      if (p) begin
        if (f0 >= 0) begin
          m_full_q.push_back(f0);
          m_written++;
          m_fill = -1;
        end else err_n = 1;
      end
      if (m_fill < 0 && m_written < m_nf && oth_empty) begin
        m_fill = oth;
        m_last_wr = oth;
      end
      if (r) begin
        if (d0 >= 0) begin
          m_drain = -1;
          m_read++;
          if (m_read == m_nf) begin
            m_run = 0; ld_n = 1; m_fill = -1; m_full_q.delete();
          end
        end else err_n = 1;
      end
    end
    m_err = err_n;
    m_ld  = ld_n;
  endtask

  function automatic logic [6:0] model_out();
    return {m_run && (m_fill >= 0), m_last_wr[0], m_drain >= 0, m_rdb[0], m_run, m_ld, m_err};
  endfunction

  initial begin
    reset = 1'b1; layer_go = 0; num_frames = 0; pool_done = 0; rd_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 7'b0000000);
    @(negedge clk);
    reset = 1'b0;

    tbl[0]  = mk(1, 1, 0, 0, 7'b1000100);
    tbl[1]  = mk(0, 0, 0, 0, 7'b1000100);
    tbl[2]  = mk(0, 0, 1, 0, 7'b0000100);
    tbl[3]  = mk(0, 0, 0, 0, 7'b0010100);
    tbl[4]  = mk(0, 0, 0, 0, 7'b0010100);
    tbl[5]  = mk(0, 0, 0, 1, 7'b0000010);
    tbl[6]  = mk(0, 0, 0, 0, 7'b0000000);
    tbl[7]  = mk(1, 3, 0, 0, 7'b1000100);
    tbl[8]  = mk(0, 0, 1, 0, 7'b1100100);
    tbl[9]  = mk(0, 0, 0, 0, 7'b1110100);
    tbl[10] = mk(0, 0, 1, 0, 7'b0110100);
    tbl[11] = mk(0, 0, 0, 0, 7'b0110100);
    tbl[12] = mk(0, 0, 0, 1, 7'b0100100);
    tbl[13] = mk(0, 0, 0, 0, 7'b1011100);
    tbl[14] = mk(0, 0, 1, 0, 7'b0011100);
    tbl[15] = mk(0, 0, 0, 1, 7'b0001100);
    tbl[16] = mk(0, 0, 0, 0, 7'b0010100);
    tbl[17] = mk(0, 0, 0, 1, 7'b0000010);
    tbl[18] = mk(0, 0, 0, 0, 7'b0000000);
    tbl[19] = mk(1, 0, 0, 0, 7'b0000010);
    tbl[20] = mk(0, 0, 0, 0, 7'b0000000);
    tbl[21] = mk(0, 0, 1, 0, 7'b0000001);
    tbl[22] = mk(0, 0, 0, 1, 7'b0000001);
    tbl[23] = mk(1, 1, 0, 0, 7'b1000100);
    tbl[24] = mk(0, 0, 1, 0, 7'b0000100);
    tbl[25] = mk(0, 0, 1, 0, 7'b0010101);
    tbl[26] = mk(1, 5, 0, 0, 7'b0010101);
    tbl[27] = mk(0, 0, 0, 1, 7'b0000011);
    tbl[28] = mk(0, 0, 0, 0, 7'b0000001);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].go, tbl[i].nf, tbl[i].pd, tbl[i].rd);
      check($sformatf("vec%0d", i), tbl[i].exp);
      $display("vec %0d go=%0d nf=%0d pd=%0d rd=%0d out=%b", i, tbl[i].go, tbl[i].nf,
               tbl[i].pd, tbl[i].rd, act);
    end

    // Mid-run reset with bank0 DRAIN and bank1 FULL (writer stalled).
    drive(1, 4, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    check("stall_before_rst", 7'b0110100);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_rst", 7'b0000000);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 0, 0);
    check("post_rst_go", 7'b1000100);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    check("post_rst_drain", 7'b0010100);
    $display("reset sequence done");

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    for (int c = 0; c < 4000; c++) begin
      bit g, p, r;
      int n;
      g = m_run ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 3) == 0);
      n = $urandom_range(0, 5);
      p = (m_fill >= 0)  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      r = (m_drain >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      drive(g, n, p, r);
      model_step(g, n, p, r);
      check($sformatf("rand%0d", c), model_out());
      if (m_ld) $display("random layer end at cycle %0d err=%0d", c, m_err);
    end

    drive(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
